// File: rtl/mem_access_ctrl_if.sv
// Data-bus interface between the MEM-stage access sequencer and data memory.
//   master : drives bus_req/bus_we/bus_addr/bus_be/bus_wdata, receives bus_ack/bus_rdata
//   slave  : memory side, mirror image of master
interface mem_access_ctrl_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [BE_W-1:0]   bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: one load/store at a time over a
// req/ack bus, with lane steering, load extension, alignment and timeout faults.
//   clk, reset             : clock (rising edge), async active-high reset
//   mem_valid/we/funct3/addr/wdata : access from the MEM stage
//   stall (comb), done, load_data, misalign, bus_err : pipeline status/result
//   bus (master modport)   : data bus request/ack
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bus_err,
  mem_access_ctrl_if.master bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              bus_req_q, bus_req_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [BE_W-1:0]   bus_be_q, bus_be_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;

  logic              bad_c;
  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] ext_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;

  // Decode of the incoming access: legality, alignment, lane enables and data.
  always_comb begin
    bad_c = (mem_funct3[1:0] == 2'b11) || (mem_funct3 == 3'b110) ||
            (mem_we && mem_funct3[2]) ||
            ((mem_funct3[1:0] == 2'b01) && mem_addr[0]) ||
            ((mem_funct3[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00));
    case (mem_funct3[1:0])
      2'b00:   begin
        be_c    = BE_W'(4'b0001 << mem_addr[1:0]);
        wdata_c = {4{mem_wdata[7:0]}};
      end
      2'b01:   begin
        be_c    = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{mem_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = mem_wdata;
      end
    endcase
  end

  // Lane select and sign/zero extension of the returned read word.
  always_comb begin
    byte_c = 8'(bus.bus_rdata >> {off_q, 3'b000});
    half_c = 16'(bus.bus_rdata >> {off_q[1], 4'b0000});
    case (funct3_q)
      3'b000:  ext_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  ext_c = {24'h0, byte_c};
      3'b001:  ext_c = {{16{half_c[15]}}, half_c};
      3'b101:  ext_c = {16'h0, half_c};
      default: ext_c = bus.bus_rdata;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    bus_req_d   = 1'b0;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    load_data_d = '0;
    stall       = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall = mem_valid;
        if (mem_valid) begin
          if (bad_c) begin
            state_d    = S_FAULT;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            bus_req_d   = 1'b1;
            cnt_d       = '0;
            we_d        = mem_we;
            funct3_d    = mem_funct3;
            off_d       = mem_addr[1:0];
            bus_addr_d  = {mem_addr[31:2], 2'b00};
            bus_be_d    = be_c;
            bus_wdata_d = wdata_c;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus.bus_ack) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          load_data_d = we_q ? '0 : ext_c;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          // Abort: reported as a completed-with-error access, store not performed.
          state_d   = S_DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          bus_req_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      load_data_q <= load_data_d;
    end
  end

  assign done          = done_q;
  assign misalign      = misalign_q;
  assign bus_err       = bus_err_q;
  assign load_data     = load_data_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (TIMEOUT=4): vector table with a
// completion scoreboard, plus a hand-written reset-during-request sequence.
module tb_mem_access_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall, done, misalign, bus_err;
  logic [31:0] load_data;

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .bus        (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_n;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] load;
    logic        mis;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] load;
    logic        mis;
    logic        err;
    int          done_cyc;
    int          req_cycles;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc     = 0;
  int req_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int wait_n,
                              input logic [3:0] be, input logic [31:0] bwdata,
                              input logic [31:0] load, input logic mis, input logic err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.wait_n = wait_n; v.be = be; v.bwdata = bwdata; v.load = load;
    v.mis = mis; v.err = err;
    return v;
  endfunction

  // Completion monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("load_data", load_data, e.load);
        chk("misalign", 32'(misalign), 32'(e.mis));
        chk("bus_err", 32'(bus_err), 32'(e.err));
        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
        chk("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
      end
    end
  end

  // Drive one access, act as the memory, check bus fields and stall each cycle.
  // mem_valid is left high through done so the next call issues back-to-back.
  task automatic run_vec(input vec_t v);
    exp_t e;
    bit   fin;
    @(posedge clk); #1;
    mem_valid  = 1'b1;
    mem_we     = v.we;
    mem_funct3 = v.f3;
    mem_addr   = v.addr;
    mem_wdata  = v.wdata;
    bus_if.bus_ack = 1'b0;
    cyc     = 0;
    req_cnt = 0;
    e.load       = v.load;
    e.mis        = v.mis;
    e.err        = v.err;
    e.done_cyc   = v.mis ? 1 : (v.err ? 1 + int'(TO) : 2 + v.wait_n);
    e.req_cycles = v.mis ? 0 : (v.err ? int'(TO) : v.wait_n + 1);
    sb_q.push_back(e);
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      chk("stall", 32'(stall), 32'(cyc < e.done_cyc));
      if (bus_if.bus_req === 1'b1) begin
        req_cnt++;
        chk("bus_we", 32'(bus_if.bus_we), 32'(v.we));
        chk("bus_addr", bus_if.bus_addr, {v.addr[31:2], 2'b00});
        chk("bus_be", 32'(bus_if.bus_be), 32'(v.be));
        if (v.we) chk("bus_wdata", bus_if.bus_wdata, v.bwdata);
      end
      if (done === 1'b1) begin
        fin = 1'b1;
      end else if (cyc > 30) begin
        chk("done_timeout", 32'(done), 32'(1));
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        if (bus_if.bus_req === 1'b1 && req_cnt == v.wait_n) begin
          bus_if.bus_ack   = 1'b1;
          bus_if.bus_rdata = v.rdata;
        end else begin
          bus_if.bus_ack   = 1'b0;
          bus_if.bus_rdata = $urandom;
        end
      end
    end
    bus_if.bus_ack = 1'b0;
  endtask

  initial begin
    //          we    f3      addr          wdata         rdata         wait be      bwdata        load          mis   err
    vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0,  4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8012_3456, 1,  4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8012_3456, 0,  4'b1000, 32'h0,        32'h0000_0080, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8012_3456, 0,  4'b1100, 32'h0,        32'h0000_8012, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h8012_8000, 2,  4'b0011, 32'h0,        32'hFFFF_8000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0,  4'b0010, 32'h0,        32'h0000_007F, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0206, 32'h1234_ABCD, 32'hFFFF_FFFF, 3,  4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'hFFFF_FFFF, 0,  4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'hFFFF_FFFF, 2,  4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h1111_1111, 0,  4'b1111, 32'h0,        32'h0,        1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 3'b100, 32'h0000_0200, 32'h5555_5555, 32'h1111_1111, 0,  4'b0001, 32'h0,        32'h0,        1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 3'b011, 32'h0000_0200, 32'h0,        32'h1111_1111, 0,  4'b1111, 32'h0,        32'h0,        1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h1111_1111, 0,  4'b1100, 32'h0,        32'h0,        1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0400, 32'h0,        32'h7777_7777, 99, 4'b1111, 32'h0,        32'h0,        1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'h1234_5678, 0,  4'b1111, 32'h0,        32'h1234_5678, 1'b0, 1'b0));

    reset            = 1'b1;
    mem_valid        = 1'b0;
    mem_we           = 1'b0;
    mem_funct3       = 3'b000;
    mem_addr         = 32'h0;
    mem_wdata        = 32'h0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;

    // Reset state
    #12;
    chk("rst_bus_req", 32'(bus_if.bus_req), 32'(0));
    chk("rst_bus_we", 32'(bus_if.bus_we), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_misalign", 32'(misalign), 32'(0));
    chk("rst_bus_err", 32'(bus_err), 32'(0));
    chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
    chk("rst_bus_be", 32'(bus_if.bus_be), 32'(0));
    chk("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_stall_lo", 32'(stall), 32'(0));
    mem_valid = 1'b1; #1;
    chk("rst_stall_hi", 32'(stall), 32'(1));
    mem_valid = 1'b0; #1;
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while a request is outstanding.
    @(posedge clk); #1;
    mem_valid  = 1'b1;
    mem_we     = 1'b0;
    mem_funct3 = 3'b010;
    mem_addr   = 32'h0000_0500;
    @(posedge clk); #1;
    chk("midrst_req_before", 32'(bus_if.bus_req), 32'(1));
    #2 reset = 1'b1;
    #1;
    chk("midrst_req_drop", 32'(bus_if.bus_req), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_ack_req", 32'(bus_if.bus_req), 32'(0));
      chk("late_ack_done", 32'(done), 32'(0));
    end
    bus_if.bus_ack = 1'b0;

    run_vec(mk(1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 1, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0));
    @(posedge clk); #1;
    mem_valid = 1'b0;
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
